// File: rtl/nrad_pkg.sv
// Shared definitions for the NRAD divider sequencing stage:
// FSM states, error codes, saturated results and the operand screen.
package nrad_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CORRECT = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIVZ = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;

   localparam logic [2:0] Q_SAT = 3'b111;
   localparam logic [2:0] R_SAT = 3'b000;

   // Quotient needs more than 3 bits when x >= 8*y.
   function automatic logic quot_ovf(input logic [3:0] x, input logic [1:0] y);
      return {1'b0, x} >= {y, 3'b000};
   endfunction

endpackage

// File: rtl/nrad_fix.sv
// Non-restoring correction: a negative raw remainder gets one divisor added
// back and the quotient is decremented (mod 8).
module nrad_fix
   import nrad_pkg::*;
(
   input  logic [2:0] div_Q,
   input  logic [2:0] div_R,
   input  logic [1:0] div_Y,
   output logic [2:0] fix_Q,
   output logic [2:0] fix_R
);

   always_comb begin
      fix_Q = div_Q;
      fix_R = div_R;
      if (div_R[2]) begin
         fix_R = div_R + {1'b0, div_Y};
         fix_Q = div_Q - 3'd1;
      end
   end

endmodule

// File: rtl/nrad_seq_ctrl.sv
// Sequencing/result stage around the combinational NRAD array divider:
// operand handshake and screening, settle wait, correction and result hold.
module nrad_seq_ctrl
   import nrad_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_X,
   input  logic [1:0] in_Y,
   output logic [3:0] div_X,
   output logic [1:0] div_Y,
   input  logic [2:0] div_Q,
   input  logic [2:0] div_R,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_Q,
   output logic [2:0] out_R,
   output logic [1:0] out_err,
   output logic       busy
);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] div_X_nxt;
   logic [1:0] div_Y_nxt;
   logic       out_valid_nxt;
   logic [2:0] out_Q_nxt, out_R_nxt;
   logic [1:0] out_err_nxt;
   logic [2:0] fix_Q, fix_R;
   logic       accept;

   nrad_fix u_fix (
      .div_Q (div_Q),
      .div_R (div_R),
      .div_Y (div_Y),
      .fix_Q (fix_Q),
      .fix_R (fix_R)
   );

   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      div_X_nxt     = div_X;
      div_Y_nxt     = div_Y;
      out_valid_nxt = out_valid;
      out_Q_nxt     = out_Q;
      out_R_nxt     = out_R;
      out_err_nxt   = out_err;

      case (state)
         SETTLE: begin
            if (cnt == 4'(SETTLE_CYC - 1)) state_nxt = CORRECT;
            else                           cnt_nxt   = cnt + 4'd1;
         end
         CORRECT: begin
            out_Q_nxt     = fix_Q;
            out_R_nxt     = fix_R;
            out_err_nxt   = ERR_OK;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: ;
      endcase

      // Accept overrides the HOLD pop above so a pop+accept is back-to-back.
      if (accept) begin
         div_X_nxt = in_X;
         div_Y_nxt = in_Y;
         if (in_Y == 2'd0 || quot_ovf(in_X, in_Y)) begin
            out_Q_nxt     = Q_SAT;
            out_R_nxt     = R_SAT;
            out_err_nxt   = (in_Y == 2'd0) ? ERR_DIVZ : ERR_OVF;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
         end else begin
            out_valid_nxt = 1'b0;
            cnt_nxt       = '0;
            state_nxt     = SETTLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_X     <= '0;
         div_Y     <= '0;
         out_valid <= 1'b0;
         out_Q     <= '0;
         out_R     <= '0;
         out_err   <= ERR_OK;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         div_X     <= div_X_nxt;
         div_Y     <= div_Y_nxt;
         out_valid <= out_valid_nxt;
         out_Q     <= out_Q_nxt;
         out_R     <= out_R_nxt;
         out_err   <= out_err_nxt;
      end
   end

endmodule

// File: tb/tb_nrad_seq_ctrl.sv
// Self-checking bench for nrad_seq_ctrl: directed scenarios plus a randomized
// sweep scored against integer division, with a behavioural NRAD array model.
module tb_nrad_seq_ctrl;

   localparam int unsigned SETTLE = 2;

   typedef struct {
      logic [2:0] q;
      logic [2:0] r;
      logic [1:0] e;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_X;
   logic [1:0] in_Y;
   logic [3:0] div_X;
   logic [1:0] div_Y;
   logic [2:0] div_Q;
   logic [2:0] div_R;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_Q;
   logic [2:0] out_R;
   logic [1:0] out_err;
   logic       busy;

   int   errors = 0;
   int   checks = 0;
   logic acc, pop;
   logic neg_form = 1'b0;
   res_t exp_q[$];
   int   aq, ar;

   nrad_seq_ctrl #(.SETTLE_CYC(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_X      (in_X),
      .in_Y      (in_Y),
      .div_X     (div_X),
      .div_Y     (div_Y),
      .div_Q     (div_Q),
      .div_R     (div_R),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_Q     (out_Q),
      .out_R     (out_R),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Array model: either the exact result or the un-corrected form with a
   // negative remainder (q+1, r-Y), chosen at random per operation.
   always_comb begin
      div_Q = '0;
      div_R = '0;
      aq    = 0;
      ar    = 0;
      if (div_Y != 2'd0) begin
         aq = int'(div_X) / int'(div_Y);
         ar = int'(div_X) % int'(div_Y);
         if (neg_form) begin
            div_Q = 3'(aq + 1);
            div_R = 3'(ar - int'(div_Y));
         end else begin
            div_Q = 3'(aq);
            div_R = 3'(ar);
         end
      end
   end

   function automatic res_t model(input int x, input int y);
      res_t m;
      if (y == 0)          m = '{3'd7, 3'd0, 2'b01};
      else if (x / y > 7)  m = '{3'd7, 3'd0, 2'b10};
      else                 m = '{3'(x / y), 3'(x % y), 2'b00};
      return m;
   endfunction

   // One clock: sample handshakes before the edge, score pops, log accepts.
   task automatic cyc();
      res_t e;
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got Q=%0d R=%0d err=%0d, required no result", out_Q, out_R, out_err);
         end else begin
            e = exp_q.pop_front();
            if ({out_Q, out_R, out_err} !== {e.q, e.r, e.e}) begin
               errors++;
               $display("FAIL sb_result: got Q=%0d R=%0d err=%0d, required Q=%0d R=%0d err=%0d",
                        out_Q, out_R, out_err, e.q, e.r, e.e);
            end
         end
      end
      if (acc) begin
         exp_q.push_back(model(int'(in_X), int'(in_Y)));
         neg_form = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (out_valid) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_X = '0; in_Y = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({div_X, div_Y, out_valid, out_Q, out_R, out_err, busy} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", {div_X, div_Y, out_valid, out_Q, out_R, out_err, busy});
      end
      rst = 1'b0;
      cyc();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_normal();
      int n;
      in_valid = 1'b1; in_X = 4'd13; in_Y = 2'd3; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      checks++;
      if (div_X !== 4'd13 || div_Y !== 2'd3) begin
         errors++;
         $display("FAIL normal_operands: got X=%0d Y=%0d, required X=13 Y=3", div_X, div_Y);
      end
      wait_valid(n);
      checks++;
      if (n != int'(SETTLE) + 1) begin
         errors++;
         $display("FAIL normal_latency: got %0d, required %0d", n, SETTLE + 1);
      end
      checks++;
      if ({out_Q, out_R, out_err} !== {3'd4, 3'd1, 2'b00}) begin
         errors++;
         $display("FAIL normal_result: got Q=%0d R=%0d err=%0d, required Q=4 R=1 err=0", out_Q, out_R, out_err);
      end
      out_ready = 1'b1;
      cyc();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL normal_pop: got valid=%b busy=%b, required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_divz();
      in_valid = 1'b1; in_X = 4'd6; in_Y = 2'd0; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_Q, out_R, out_err, busy} !== {1'b1, 3'd7, 3'd0, 2'b01, 1'b1}) begin
         errors++;
         $display("FAIL divz: got valid=%b Q=%0d R=%0d err=%0d busy=%b, required 1 7 0 1 1",
                  out_valid, out_Q, out_R, out_err, busy);
      end
      out_ready = 1'b1;
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL divz_pop: got valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_overflow();
      int n;
      in_valid = 1'b1; in_X = 4'd15; in_Y = 2'd1; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_Q, out_R, out_err} !== {1'b1, 3'd7, 3'd0, 2'b10}) begin
         errors++;
         $display("FAIL ovf: got valid=%b Q=%0d R=%0d err=%0d, required 1 7 0 2", out_valid, out_Q, out_R, out_err);
      end
      // Pop the overflow and accept the boundary case in the same cycle.
      out_ready = 1'b1; in_valid = 1'b1; in_X = 4'd7; in_Y = 2'd1;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (acc !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_b2b: got acc=%b valid=%b, required 1 0", acc, out_valid);
      end
      wait_valid(n);
      checks++;
      if (n != int'(SETTLE) + 1 || {out_Q, out_R, out_err} !== {3'd7, 3'd0, 2'b00}) begin
         errors++;
         $display("FAIL ovf_boundary: got n=%0d Q=%0d R=%0d err=%0d, required n=%0d 7 0 0",
                  n, out_Q, out_R, out_err, SETTLE + 1);
      end
      out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_backpressure();
      int n;
      in_valid = 1'b1; in_X = 4'd9; in_Y = 2'd2; out_ready = 1'b0;
      cyc();
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_X = 4'($urandom); in_Y = 2'($urandom);
         cyc();
         checks++;
         if ({out_valid, out_Q, out_R, in_ready, acc} !== {1'b1, 3'd4, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b Q=%0d R=%0d in_ready=%b acc=%b, required 1 4 1 0 0",
                     i, out_valid, out_Q, out_R, in_ready, acc);
         end
      end
      out_ready = 1'b1; in_valid = 1'b1; in_X = 4'd10; in_Y = 2'd3;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (acc !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_b2b: got acc=%b valid=%b, required 1 0", acc, out_valid);
      end
      wait_valid(n);
      checks++;
      if ({out_Q, out_R, out_err} !== {3'd3, 3'd1, 2'b00}) begin
         errors++;
         $display("FAIL bp_second: got Q=%0d R=%0d err=%0d, required 3 1 0", out_Q, out_R, out_err);
      end
      out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_reset_mid();
      int n;
      in_valid = 1'b1; in_X = 4'd11; in_Y = 2'd2; out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      cyc();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_settle: got busy=%b valid=%b, required 1 0", busy, out_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({div_X, div_Y, out_valid, out_Q, out_R, out_err, busy} !== 16'd0) begin
         errors++;
         $display("FAIL rm_async: got %h, required 0", {div_X, div_Y, out_valid, out_Q, out_R, out_err, busy});
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale%0d: got valid=%b, required 0", i, out_valid);
         end
      end
      out_ready = 1'b0; in_valid = 1'b1; in_X = 4'd5; in_Y = 2'd2;
      cyc();
      in_valid = 1'b0;
      wait_valid(n);
      checks++;
      if (n != int'(SETTLE) + 1 || {out_Q, out_R, out_err} !== {3'd2, 3'd1, 2'b00}) begin
         errors++;
         $display("FAIL rm_after: got n=%0d Q=%0d R=%0d err=%0d, required n=%0d 2 1 0",
                  n, out_Q, out_R, out_err, SETTLE + 1);
      end
      out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_sweep();
      int pairs[$];
      int j, tmp, tries, nacc;
      for (int i = 0; i < 64; i++) pairs.push_back(i);
      for (int i = 63; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
      end
      nacc = 0;
      foreach (pairs[k]) begin
         tries = 0;
         do begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_X      = 4'(pairs[k] >> 2);
            in_Y      = 2'(pairs[k]);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            tries++;
         end while (!acc && tries < 60);
         if (acc) nacc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tries = 0;
      while ((exp_q.size() != 0 || out_valid) && tries < 60) begin
         cyc();
         tries++;
      end
      checks++;
      if (nacc != 64 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL sweep_drain: got accepted=%0d pending=%0d, required 64 0", nacc, exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal();
      test_divz();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nrad_seq_ctrl.md
Name: nrad_seq_ctrl

Overview:
Sequencing and result stage wrapped around the combinational NRAD array divider (4-bit dividend, 2-bit divisor, 3-bit raw Q/R).
- Accepts operand pairs over a valid/ready handshake and screens out divide-by-zero and quotient overflow.
- Drives the array and waits a fixed settle time, then samples the raw quotient/remainder and applies the non-restoring remainder correction.
- Presents the corrected result over a valid/ready handshake to downstream logic.

Parameters:
SETTLE_CYC, 2, clock cycles the array outputs are given to settle before sampling; legal range 1..15.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair
in_X  in  4  dividend, unsigned
in_Y  in  2  divisor, unsigned
div_X  out  4  dividend driven to the NRAD array
div_Y  out  2  divisor driven to the NRAD array
div_Q  in  3  raw quotient from the NRAD array
div_R  in  3  raw remainder from the NRAD array, two's complement
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_Q  out  3  corrected quotient
out_R  out  3  corrected remainder
out_err  out  2  00 ok, 01 divide-by-zero, 10 overflow
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, settle counter=0.
  - div_X=0, div_Y=0, out_valid=0, out_Q=0, out_R=0, out_err=00, busy=0.
  - An in-flight operation is dropped; no result is emitted for it.
- States: IDLE, SETTLE, CORRECT, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). An accept and a pop in the same cycle are legal and give back-to-back operation.
- Accept is in_valid & in_ready at edge t. On accept, in_X and in_Y are registered into div_X and div_Y. These stay stable until the next accept.
- Screening at accept, using the incoming operands:
  - in_Y==0: err=01, go straight to HOLD. out_Q=3'b111, out_R=3'b000, out_valid=1 after edge t+1... more precisely, out_valid is asserted from edge t onward (1-cycle latency).
  - in_Y!=0 and in_X >= 8*in_Y: quotient does not fit in 3 bits. err=10, go straight to HOLD with out_Q=3'b111, out_R=3'b000.
  - Otherwise: go to SETTLE with counter=0.
- SETTLE: the counter increments every cycle. When counter==SETTLE_CYC-1, move to CORRECT.
- CORRECT, one cycle. Sample div_Q and div_R and register the corrected result:
  - if div_R[2]==1 (negative remainder): out_R = div_R + {1'b0,div_Y}, out_Q = div_Q - 1 (mod 8);
  - else out_R = div_R, out_Q = div_Q.
  - Then go to HOLD with out_valid=1 and out_err=00.
- Latency, accept edge to out_valid=1:
  - valid operations: SETTLE_CYC+1 edges (accept at t, out_valid rises at edge t+SETTLE_CYC+1);
  - error cases: out_valid rises at edge t itself.
- HOLD:
  - out_Q, out_R and out_err are held stable while out_valid & !out_ready, for any number of cycles.
  - On out_ready with no new accept: out_valid=0 and state returns to IDLE.
  - On out_ready with a simultaneous accept: out_valid drops for the new operation (or stays 1 for an error-path operation, with the new values) and the state follows the screening rules above.
- Correctness requirement: for every non-error input pair, out_Q == in_X / in_Y and out_R == in_X % in_Y. The bench checks against this, independent of the correction mechanism.
- in_X and in_Y are ignored while in_ready==0.

Decomposition:
- Shared package `nrad_pkg`:
  - state encoding (IDLE=0, SETTLE=1, CORRECT=2, HOLD=3);
  - error codes (ERR_OK=2'b00, ERR_DIVZ=2'b01, ERR_OVF=2'b10);
  - saturation constants Q_SAT=3'b111, R_SAT=3'b000.
- One sub-module, `nrad_fix`: purely combinational remainder/quotient correction. Inputs div_Q, div_R, div_Y; outputs the corrected Q and R. Instantiated in the CORRECT path.
- The operand screen (zero/overflow compare) stays inline.

Test Plan:
- Normal divide, SETTLE_CYC=2: X=13, Y=3 accepted at edge t -> out_valid rises at edge t+3, out_Q=4, out_R=1, out_err=00.
- Divide-by-zero: X=6, Y=0 -> out_valid at edge t, out_err=01, out_Q=7, out_R=0, and the NRAD array result is never sampled.
- Overflow: X=15, Y=1 -> out_err=10, out_Q=7, out_R=0. Then X=7, Y=1 -> out_Q=7, out_R=0, out_err=00 (boundary just below overflow).
- Backpressure: X=9, Y=2 with out_ready=0 for 5 cycles after out_valid -> out_Q=4, out_R=1 held stable and in_ready=0 throughout. Raising out_ready together with a new in_valid (X=10, Y=3) -> the new operand is accepted the same cycle and later yields out_Q=3, out_R=1.
- Reset mid-operation: assert rst during SETTLE for X=11, Y=2 -> all outputs return to reset values immediately (asynchronously). After release, X=5, Y=2 -> out_Q=2, out_R=1, and no stale result appears.
- Exhaustive sweep: all 16x4 operand pairs with random out_ready -> each result matches integer division or carries the correct err code, with one result per accepted operand and in order.
